// File: rtl/muldiv_sequencer.sv
// Iterative RV M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_EARLY_OUT_EN to retire zero-operand, divide-by-zero and MIN/-1 cases one cycle after accept.
module muldiv_sequencer #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_start,
    input  logic [2:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_src_1,
    input  logic [DATA_WIDTH-1:0] i_src_2,
    input  logic                  i_flush,
    output logic                  o_stall,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;

    logic [2:0]              op_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   opnd_q;
    logic [2*DATA_WIDTH-1:0] prod_q;
    logic                    sa_q, sb_q, div0_q, ovf_q, zero_q;

    logic                    accept, done_fire;
    logic                    is_div, signed_a, signed_b, sa, sb;
    logic                    div0, ovf, zero, early;
    logic [DATA_WIDTH-1:0]   mag_a, mag_b;
    logic [2*DATA_WIDTH-1:0] prod_fix;
    logic [DATA_WIDTH-1:0]   quo_s, rem_s, res_comb;

    // Upper half accumulates the multiplicand while the multiplier shifts out of the low half.
    function automatic logic [2*DATA_WIDTH-1:0] mul_step(input logic [2*DATA_WIDTH-1:0] p,
                                                         input logic [DATA_WIDTH-1:0]   m);
        logic [DATA_WIDTH:0] sum;
        sum = {1'b0, p[2*DATA_WIDTH-1:DATA_WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {sum, p[DATA_WIDTH-1:1]};
    endfunction

    // Upper half is the partial remainder; the low half shifts dividend bits out and quotient bits in.
    function automatic logic [2*DATA_WIDTH-1:0] div_step(input logic [2*DATA_WIDTH-1:0] p,
                                                         input logic [DATA_WIDTH-1:0]   d);
        logic [DATA_WIDTH:0] rs, diff;
        rs   = {p[2*DATA_WIDTH-1:DATA_WIDTH], p[DATA_WIDTH-1]};
        diff = rs - {1'b0, d};
        if (!diff[DATA_WIDTH])
            return {diff[DATA_WIDTH-1:0], p[DATA_WIDTH-2:0], 1'b1};
        else
            return {rs[DATA_WIDTH-1:0], p[DATA_WIDTH-2:0], 1'b0};
    endfunction

    always_comb begin
        is_div   = i_op[2];
        signed_a = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
        signed_b = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
        sa       = signed_a & i_src_1[DATA_WIDTH-1];
        sb       = signed_b & i_src_2[DATA_WIDTH-1];
        mag_a    = sa ? -i_src_1 : i_src_1;
        mag_b    = sb ? -i_src_2 : i_src_2;
        div0     = is_div && (i_src_2 == '0);
        ovf      = is_div && !i_op[0] && (i_src_1 == MIN_VAL) && (i_src_2 == '1);
        zero     = is_div ? (i_src_1 == '0) : ((i_src_1 == '0) || (i_src_2 == '0));
        early    = div0 | ovf | zero;
        accept   = (state_q == S_IDLE) && i_start && !i_flush;
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef MULDIV_EARLY_OUT_EN
                    state_d = early ? S_DONE : S_CALC;
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (i_flush)
                    state_d = S_IDLE;
                else if (cnt_q == '0)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept)
            cnt_d = CNT_WIDTH'(DATA_WIDTH - 1);
        else if ((state_q == S_CALC) && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    // Datapath registers carry no reset; they are only observed through the DONE result.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_q   <= i_op;
            a_q    <= i_src_1;
            sa_q   <= sa;
            sb_q   <= sb;
            div0_q <= div0;
            ovf_q  <= ovf;
            zero_q <= zero;
            opnd_q <= is_div ? mag_b : mag_a;
            prod_q <= {{DATA_WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        end else if (state_q == S_CALC) begin
            prod_q <= op_q[2] ? div_step(prod_q, opnd_q) : mul_step(prod_q, opnd_q);
        end
    end

    always_comb begin
        prod_fix = (sa_q ^ sb_q) ? -prod_q : prod_q;
        quo_s    = (sa_q ^ sb_q) ? -prod_q[DATA_WIDTH-1:0] : prod_q[DATA_WIDTH-1:0];
        rem_s    = sa_q ? -prod_q[2*DATA_WIDTH-1:DATA_WIDTH] : prod_q[2*DATA_WIDTH-1:DATA_WIDTH];
        res_comb = '0;
        case (op_q)
            3'd0:       res_comb = prod_fix[DATA_WIDTH-1:0];
            3'd1, 3'd2,
            3'd3:       res_comb = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            3'd4, 3'd5: res_comb = div0_q ? '1 : (ovf_q ? MIN_VAL : quo_s);
            default:    res_comb = div0_q ? a_q : (ovf_q ? '0 : rem_s);
        endcase
        if (zero_q && !div0_q)
            res_comb = '0;
    end

    always_comb begin
        done_fire = (state_q == S_DONE) && !i_flush;
        result_d  = done_fire ? res_comb : result_q;
        o_stall   = accept || (state_q == S_CALC);
        o_busy    = (state_q != S_IDLE);
        o_done    = done_fire;
        o_result  = done_fire ? res_comb : result_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer at DATA_WIDTH=64: results, latency, stall, flush and async reset.
module tb_muldiv_sequencer;
    logic        i_clk = 1'b0;
    logic        i_arst;
    logic        i_start;
    logic [2:0]  i_op;
    logic [63:0] i_src_1, i_src_2;
    logic        i_flush;
    logic        o_stall, o_busy, o_done;
    logic [63:0] o_result;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [63:0] prev_res;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 1;
`else
    localparam int LAT_SPECIAL = 65;
`endif
    localparam int LAT_FULL = 65;

    muldiv_sequencer #(.DATA_WIDTH(64)) dut (
        .i_clk   (i_clk),
        .i_arst  (i_arst),
        .i_start (i_start),
        .i_op    (i_op),
        .i_src_1 (i_src_1),
        .i_src_2 (i_src_2),
        .i_flush (i_flush),
        .o_stall (o_stall),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_result(o_result)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%016h want=0x%016h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge with the unit idle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        int cyc;
        int stalls;
        i_op = op; i_src_1 = a; i_src_2 = b; i_start = 1'b1;
        #1;
        chk({tag, " hold_prev"}, o_result, prev_res);
        cyc = 0; stalls = 0;
        while (!o_done && cyc < 200) begin
            if (o_stall) stalls++;
            @(posedge i_clk); #1;
            cyc++;
            if (cyc == 2) begin
                i_src_1 = ~a; i_src_2 = a ^ b; i_op = ~op;
            end
        end
        chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, " result"}, o_result, exp);
        chk({tag, " stall_done"}, {63'd0, o_stall}, 64'd0);
        chk({tag, " stall_cycles"}, 64'(stalls), 64'(exp_lat));
        @(posedge i_clk); #1;
        i_start = 1'b0;
        #1;
        chk({tag, " done_once"}, {63'd0, o_done}, 64'd0);
        chk({tag, " idle_after"}, {63'd0, o_busy}, 64'd0);
        chk({tag, " result_held"}, o_result, exp);
        prev_res = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        i_arst = 1'b1; i_start = 1'b0; i_op = 3'd0; i_src_1 = '0; i_src_2 = '0; i_flush = 1'b0;
        prev_res = '0;
        @(posedge i_clk); #1;
        chk("rst busy", {63'd0, o_busy}, 64'd0);
        chk("rst done", {63'd0, o_done}, 64'd0);
        chk("rst result", o_result, 64'd0);
        chk("rst stall", {63'd0, o_stall}, 64'd0);
        i_arst = 1'b0;
        @(posedge i_clk); #1;

        run_op("MUL 7x-3", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, LAT_FULL);
        run_op("MULHU ones", 3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, LAT_FULL);
        run_op("MULH ones", 3'd1, '1, '1, 64'd0, LAT_FULL);
        run_op("MULHSU -1x2", 3'd2, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_FULL);
        run_op("DIV -20/3", 3'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, LAT_FULL);
        run_op("REM -20/3", 3'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, LAT_FULL);
        run_op("DIVU 100/7", 3'd5, 64'd100, 64'd7, 64'd14, LAT_FULL);
        run_op("REMU 100/7", 3'd7, 64'd100, 64'd7, 64'd2, LAT_FULL);
        run_op("DIVU 5/0", 3'd5, 64'd5, 64'd0, '1, LAT_SPECIAL);
        run_op("REM 5/0", 3'd6, 64'd5, 64'd0, 64'd5, LAT_SPECIAL);
        run_op("DIV MIN/-1", 3'd4, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, LAT_SPECIAL);

        // Flush ten cycles into CALC.
        i_op = 3'd0; i_src_1 = 64'd5; i_src_2 = 64'd5; i_start = 1'b1;
        repeat (10) @(posedge i_clk);
        #1;
        i_flush = 1'b1; i_start = 1'b0;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        #1;
        chk("flush busy", {63'd0, o_busy}, 64'd0);
        chk("flush stall", {63'd0, o_stall}, 64'd0);
        chk("flush result", o_result, prev_res);
        dn = 0;
        repeat (70) begin
            @(posedge i_clk); #1;
            if (o_done) dn++;
        end
        chk("flush no_done", 64'(dn), 64'd0);
        run_op("DIVU after flush", 3'd5, 64'd100, 64'd7, 64'd14, LAT_FULL);

        // Start together with flush in IDLE is not accepted.
        i_op = 3'd0; i_src_1 = 64'd3; i_src_2 = 64'd3; i_start = 1'b1; i_flush = 1'b1;
        #1;
        chk("idle flush stall", {63'd0, o_stall}, 64'd0);
        @(posedge i_clk); #1;
        chk("idle flush busy", {63'd0, o_busy}, 64'd0);
        i_start = 1'b0; i_flush = 1'b0;
        @(posedge i_clk); #1;

        // Asynchronous reset in the middle of CALC.
        i_op = 3'd0; i_src_1 = 64'd9; i_src_2 = 64'd9; i_start = 1'b1;
        repeat (20) @(posedge i_clk);
        #1;
        i_start = 1'b0;
        #2;
        i_arst = 1'b1;
        #1;
        chk("arst busy", {63'd0, o_busy}, 64'd0);
        chk("arst done", {63'd0, o_done}, 64'd0);
        chk("arst result", o_result, 64'd0);
        chk("arst stall", {63'd0, o_stall}, 64'd0);
        @(posedge i_clk); #1;
        i_arst = 1'b0;
        prev_res = '0;
        @(posedge i_clk); #1;
        run_op("MUL 2x3 post-rst", 3'd0, 64'd2, 64'd3, 64'd6, LAT_FULL);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
